// File: rtl/line_readout_sequencer.sv
// -----------------------------------------------------------------------------
// line_readout_sequencer
//   Moves one image line at a time through the pixel datapath. It collects
//   PIXELS bytes from the host and shifts them serially into the external
//   shift register (pixel 0 first, MSB first). It then pulses load and waits
//   SETTLE_CYCLES for the frequency counters to settle. Finally it scans each
//   pixel's PERIOD out over a valid/ready result stream. This repeats for
//   LINES lines per frame.
//
// Ports
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   start, abort      begin frame (IDLE only) / synchronous abort to IDLE
//   pix_data/valid    pixel byte stream from host; pix_ready = accept (FILL)
//   shift_out, load   serial bit and one-cycle load strobe to shift_register
//   pix_sel           slot select for external PERIOD mux; period_in = result
//   res_data/index    captured PERIOD and pixel order index k
//   res_valid/ready   result handshake; result held until accepted
//   line_idx          current line number
//   busy              high outside IDLE
//   frame_done        one-cycle pulse after the last result of the last line
// -----------------------------------------------------------------------------
module line_readout_sequencer #(
   parameter int unsigned PIXELS        = 16,
   parameter int unsigned PIX_BITS      = 8,
   parameter int unsigned COUNTER_BITS  = 15,
   parameter int unsigned SETTLE_CYCLES = 50000,
   parameter int unsigned LINES         = 16
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        start,
   input  logic                        abort,
   input  logic [PIX_BITS-1:0]         pix_data,
   input  logic                        pix_valid,
   output logic                        pix_ready,
   output logic                        shift_out,
   output logic                        load,
   output logic [$clog2(PIXELS)-1:0]   pix_sel,
   input  logic [COUNTER_BITS-1:0]     period_in,
   output logic [COUNTER_BITS-1:0]     res_data,
   output logic [$clog2(PIXELS)-1:0]   res_index,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [$clog2(LINES):0]      line_idx,
   output logic                        busy,
   output logic                        frame_done
);

   localparam int unsigned SHIFT_LEN = PIXELS * PIX_BITS;
   localparam int unsigned CNT_MAX   = (SHIFT_LEN > SETTLE_CYCLES) ? SHIFT_LEN : SETTLE_CYCLES;
   localparam int unsigned CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned KW        = $clog2(PIXELS);
   localparam int unsigned LW        = $clog2(LINES) + 1;

   localparam logic [CW-1:0] FILL_LAST   = CW'(PIXELS - 1);
   localparam logic [CW-1:0] SHIFT_LAST  = CW'(SHIFT_LEN - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [KW-1:0] K_LAST      = KW'(PIXELS - 1);
   localparam logic [LW-1:0] LINE_LAST   = LW'(LINES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_SHIFT, S_LOAD, S_SETTLE, S_SCAN_SEL, S_SCAN_OUT
   } state_t;

   state_t                    r_state, w_next;
   logic [CW-1:0]             r_cnt;        // fill / shift / settle counter
   logic [KW-1:0]             r_k;          // scan index
   logic [LW-1:0]             r_line;
   logic [SHIFT_LEN-1:0]      r_sr;         // line buffer, pixel 0 ends up at MSB
   logic [COUNTER_BITS-1:0]   r_res_data;
   logic [KW-1:0]             r_res_index;
   logic                      r_frame_done;
   logic                      w_accept;
   logic                      w_hs;

   assign res_data   = r_res_data;
   assign res_index  = r_res_index;
   assign line_idx   = r_line;
   assign frame_done = r_frame_done;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      pix_ready = 1'b0;
      load      = 1'b0;
      res_valid = 1'b0;
      shift_out = 1'b0;
      pix_sel   = '0;
      busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:     if (start) w_next = S_FILL;
         S_FILL: begin
            pix_ready = 1'b1;
            if (pix_valid && (r_cnt == FILL_LAST)) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            shift_out = r_sr[SHIFT_LEN-1];
            if (r_cnt == SHIFT_LAST) w_next = S_LOAD;
         end
         S_LOAD: begin
            load   = 1'b1;
            w_next = S_SETTLE;
         end
         S_SETTLE:   if (r_cnt == SETTLE_LAST) w_next = S_SCAN_SEL;
         S_SCAN_SEL: begin
            pix_sel = K_LAST - r_k;
            w_next  = S_SCAN_OUT;
         end
         S_SCAN_OUT: begin
            pix_sel   = K_LAST - r_k;
            res_valid = 1'b1;
            if (res_ready) begin
               if (r_k != K_LAST)           w_next = S_SCAN_SEL;
               else if (r_line == LINE_LAST) w_next = S_IDLE;
               else                          w_next = S_FILL;
            end
         end
         default:    w_next = S_IDLE;
      endcase
      // Abort also masks the strobes in its own cycle so no handshake or load
      // can slip through while the sequencer is being torn down.
      if (abort) begin
         w_next    = S_IDLE;
         pix_ready = 1'b0;
         load      = 1'b0;
         res_valid = 1'b0;
         shift_out = 1'b0;
      end
      w_accept = pix_ready & pix_valid;
      w_hs     = res_valid & res_ready;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt        <= '0;
         r_k          <= '0;
         r_line       <= '0;
         r_sr         <= '0;
         r_res_data   <= '0;
         r_res_index  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (abort) begin
            r_cnt  <= '0;
            r_k    <= '0;
            r_line <= '0;
            r_sr   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  r_k   <= '0;
                  if (start) r_line <= '0;
               end
               S_FILL: if (w_accept) begin
                  r_sr  <= {r_sr[SHIFT_LEN-PIX_BITS-1:0], pix_data};
                  r_cnt <= (r_cnt == FILL_LAST) ? '0 : r_cnt + CW'(1);
               end
               S_SHIFT: begin
                  r_sr  <= {r_sr[SHIFT_LEN-2:0], 1'b0};
                  r_cnt <= (r_cnt == SHIFT_LAST) ? '0 : r_cnt + CW'(1);
               end
               S_SETTLE:   r_cnt <= (r_cnt == SETTLE_LAST) ? '0 : r_cnt + CW'(1);
               S_SCAN_SEL: begin
                  r_res_data  <= period_in;
                  r_res_index <= r_k;
               end
               S_SCAN_OUT: if (w_hs) begin
                  if (r_k == K_LAST) begin
                     r_k <= '0;
                     if (r_line == LINE_LAST) begin
                        r_line       <= '0;
                        r_frame_done <= 1'b1;
                     end else begin
                        r_line <= r_line + LW'(1);
                     end
                  end else begin
                     r_k <= r_k + KW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_line_readout_sequencer.sv
// -----------------------------------------------------------------------------
// tb_line_readout_sequencer
//   Directed bench for line_readout_sequencer with PIXELS=4, LINES=2 and
//   SETTLE_CYCLES=10. The PERIOD mux is modelled as period_in = base + pix_sel.
//   The shift_register is modelled as a 32-bit serial capture of shift_out.
// -----------------------------------------------------------------------------
module tb_line_readout_sequencer;

   localparam int unsigned PIXELS = 4;
   localparam int unsigned PIX_BITS = 8;
   localparam int unsigned CB = 15;
   localparam int unsigned SETTLE = 10;
   localparam int unsigned LINES = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [7:0]    pix_data = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic          shift_out;
   logic          load;
   logic [1:0]    pix_sel;
   logic [14:0]   period_in;
   logic [14:0]   res_data;
   logic [1:0]    res_index;
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [1:0]    line_idx;
   logic          busy;
   logic          frame_done;

   logic [14:0]   pbase = 15'd100;
   assign period_in = pbase + {13'd0, pix_sel};

   line_readout_sequencer #(
      .PIXELS(PIXELS), .PIX_BITS(PIX_BITS), .COUNTER_BITS(CB),
      .SETTLE_CYCLES(SETTLE), .LINES(LINES)
   ) dut (
      .CLK(CLK), .RST(RST), .start(start), .abort(abort),
      .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .shift_out(shift_out), .load(load), .pix_sel(pix_sel),
      .period_in(period_in), .res_data(res_data), .res_index(res_index),
      .res_valid(res_valid), .res_ready(res_ready), .line_idx(line_idx),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 CLK = ~CLK;

   int          cyc = 0;
   int          n_load = 0;
   int          t_load = 0;
   int          n_fd = 0;
   int          n_rv = 0;
   logic [31:0] sr = '0;
   logic [31:0] sr_at_load = '0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Serial capture of shift_out plus event counters, sampled mid-cycle.
   always @(negedge CLK) begin
      if (load) begin
         n_load     <= n_load + 1;
         t_load     <= cyc;
         sr_at_load <= sr;
      end
      sr <= {sr[30:0], shift_out};
      if (frame_done) n_fd <= n_fd + 1;
      if (res_valid)  n_rv <= n_rv + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   logic [7:0] bytes [4];

   task automatic feed(input bit gaps);
      bit acc;
      for (int i = 0; i < 4; i++) begin
         if (gaps) begin
            pix_valid = 1'b0;
            repeat (2) begin @(posedge CLK); #1; start = 1'b0; end
         end
         pix_data  = bytes[i];
         pix_valid = 1'b1;
         acc = 1'b0;
         for (int w = 0; w < 40 && !acc; w++) begin
            @(negedge CLK);
            acc = pix_ready;
            @(posedge CLK); #1;
            start = 1'b0;
         end
         chk($sformatf("feed_accept_%0d", i), {31'd0, acc}, 32'd1);
      end
      pix_valid = 1'b0;
   endtask

   task automatic wait_load(input int nl);
      bit got;
      got = 1'b0;
      for (int w = 0; w < 200 && !got; w++) begin
         @(negedge CLK); #1;
         got = (n_load != nl);
      end
      chk("load_seen", {31'd0, got}, 32'd1);
   endtask

   task automatic run_line(input int ln, input bit gaps, input logic [14:0] base);
      int nl;
      int got;
      nl = n_load;
      pbase = base;
      feed(gaps);
      wait_load(nl);
      chk($sformatf("line%0d_load_count", ln), n_load, nl + 1);
      chk($sformatf("line%0d_shift_word", ln), sr_at_load, 32'hA53CFF00);
      res_ready = 1'b1;
      got = 0;
      for (int w = 0; w < 80 && got < 4; w++) begin
         @(negedge CLK); #1;
         if (res_valid) begin
            chk($sformatf("line%0d_res_index", ln), {30'd0, res_index}, got);
            chk($sformatf("line%0d_res_data_k%0d", ln, got), {17'd0, res_data}, {17'd0, base} + 32'(3 - got));
            chk($sformatf("line%0d_line_idx", ln), {30'd0, line_idx}, ln);
            got++;
         end
      end
      chk($sformatf("line%0d_result_count", ln), got, 4);
   endtask

   task automatic chk_frame_end(input string nm, input int fd0);
      @(negedge CLK); #1;
      chk({nm, "_frame_done"}, {31'd0, frame_done}, 32'd1);
      chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
      repeat (3) begin @(negedge CLK); #1; end
      chk({nm, "_frame_done_once"}, n_fd, fd0 + 1);
   endtask

   typedef struct {
      logic        rdy;
      logic        vld;
      logic [1:0]  sel;
      logic [1:0]  idx;
      logic [14:0] data;
      logic [1:0]  line;
      logic        prdy;
   } vec_t;

   vec_t tbl [14];

   int t_start;
   int nl0;
   int nrv0;
   int fd0;
   bit seen;

   initial begin
      // Scan of line 0 starting at the SCAN_SEL cycle, backpressure rows 1..5.
      tbl[0]  = '{1'b0, 1'b0, 2'd3, 2'd0, 15'd0,   2'd0, 1'b0};
      for (int i = 1; i <= 5; i++)
         tbl[i] = '{1'b0, 1'b1, 2'd3, 2'd0, 15'd103, 2'd0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 2'd3, 2'd0, 15'd103, 2'd0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 2'd2, 2'd0, 15'd103, 2'd0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 2'd2, 2'd1, 15'd102, 2'd0, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 2'd1, 2'd1, 15'd102, 2'd0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 2'd1, 2'd2, 15'd101, 2'd0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 2'd0, 2'd2, 15'd101, 2'd0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 2'd0, 2'd3, 15'd100, 2'd0, 1'b0};
      tbl[13] = '{1'b1, 1'b0, 2'd0, 2'd3, 15'd100, 2'd1, 1'b1};
      bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h00;

      // Reset state
      repeat (2) @(posedge CLK);
      @(negedge CLK); #1;
      chk("rst_outputs", {pix_ready, shift_out, load, pix_sel, res_data, res_index,
                          res_valid, line_idx, busy, frame_done}, 32'd0);
      @(posedge CLK); #1; RST = 1'b0;
      @(negedge CLK); #1;
      chk("post_rst_busy", {31'd0, busy}, 32'd0);

      // T1: minimum-latency fill and shift, then T2/T3 scan from the table
      @(posedge CLK); #1;
      start = 1'b1; t_start = cyc;
      nl0 = n_load;
      feed(1'b0);
      wait_load(nl0);
      chk("t1_load_latency", t_load - t_start, 37);
      chk("t1_shift_word", sr_at_load, 32'hA53CFF00);
      chk("t1_load_once", n_load, nl0 + 1);
      for (int i = 0; i < int'(SETTLE); i++) begin
         @(negedge CLK); #1;
         chk($sformatf("settle%0d_no_valid", i), {30'd0, busy, res_valid}, 32'd2);
      end
      for (int i = 0; i < 14; i++) begin
         @(posedge CLK); #1;
         res_ready = tbl[i].rdy;
         @(negedge CLK); #1;
         chk($sformatf("row%0d_res_valid", i), {31'd0, res_valid}, {31'd0, tbl[i].vld});
         chk($sformatf("row%0d_pix_sel", i),   {30'd0, pix_sel},   {30'd0, tbl[i].sel});
         chk($sformatf("row%0d_res_index", i), {30'd0, res_index}, {30'd0, tbl[i].idx});
         chk($sformatf("row%0d_res_data", i),  {17'd0, res_data},  {17'd0, tbl[i].data});
         chk($sformatf("row%0d_line_idx", i),  {30'd0, line_idx},  {30'd0, tbl[i].line});
         chk($sformatf("row%0d_pix_ready", i), {31'd0, pix_ready}, {31'd0, tbl[i].prdy});
      end
      chk("t4_no_early_frame_done", n_fd, 0);

      // T3/T4: second line with pix_valid gaps, then end of frame
      fd0 = n_fd;
      run_line(1, 1'b1, 15'd200);
      chk_frame_end("t4", fd0);

      // T5a: abort mid-SHIFT
      @(posedge CLK); #1;
      start = 1'b1;
      feed(1'b0);
      repeat (5) begin @(posedge CLK); #1; end
      abort = 1'b1;
      @(negedge CLK); #1;
      chk("t5a_abort_shift_out", {31'd0, shift_out}, 32'd0);
      chk("t5a_abort_load", {31'd0, load}, 32'd0);
      @(posedge CLK); #1; abort = 1'b0;
      @(negedge CLK); #1;
      chk("t5a_idle_busy", {31'd0, busy}, 32'd0);
      chk("t5a_line_idx", {30'd0, line_idx}, 32'd0);
      nl0 = n_load;
      repeat (60) begin @(negedge CLK); #1; end
      chk("t5a_no_load", n_load, nl0);

      // T5b: abort mid-SETTLE
      @(posedge CLK); #1;
      start = 1'b1;
      feed(1'b0);
      wait_load(nl0);
      repeat (3) begin @(posedge CLK); #1; end
      abort = 1'b1;
      @(posedge CLK); #1; abort = 1'b0;
      @(negedge CLK); #1;
      chk("t5b_idle_busy", {31'd0, busy}, 32'd0);
      nl0 = n_load; nrv0 = n_rv; fd0 = n_fd;
      repeat (30) begin @(negedge CLK); #1; end
      chk("t5b_no_load", n_load, nl0);
      chk("t5b_no_result", n_rv, nrv0);
      chk("t5b_no_frame_done", n_fd, fd0);

      // abort together with start in IDLE stays IDLE
      @(posedge CLK); #1; start = 1'b1; abort = 1'b1;
      @(posedge CLK); #1; start = 1'b0; abort = 1'b0;
      @(negedge CLK); #1;
      chk("abort_start_idle", {31'd0, busy}, 32'd0);

      // T5c: clean restart, full frame
      @(posedge CLK); #1;
      start = 1'b1; t_start = cyc;
      fd0 = n_fd;
      run_line(0, 1'b0, 15'd300);
      chk("t5c_load_latency", t_load - t_start, 37);
      run_line(1, 1'b0, 15'd300);
      chk_frame_end("t5c", fd0);

      // T6: RST during SCAN_OUT
      @(posedge CLK); #1;
      start = 1'b1; res_ready = 1'b0; pbase = 15'd100;
      nl0 = n_load;
      feed(1'b0);
      wait_load(nl0);
      seen = 1'b0;
      for (int w = 0; w < 40 && !seen; w++) begin
         @(negedge CLK); #1;
         seen = res_valid;
      end
      chk("t6_reach_scan_out", {31'd0, seen}, 32'd1);
      #1 RST = 1'b1;
      #1;
      chk("t6_async_rst_outputs", {pix_ready, shift_out, load, pix_sel, res_data, res_index,
                                   res_valid, line_idx, busy, frame_done}, 32'd0);
      @(posedge CLK); #1; RST = 1'b0; res_ready = 1'b1;
      @(posedge CLK); #1;
      start = 1'b1;
      fd0 = n_fd;
      run_line(0, 1'b0, 15'd100);
      run_line(1, 1'b0, 15'd100);
      chk_frame_end("t6", fd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

endmodule
